pinwheel_regfile_ctrl: RTL and testbench

Sequencer and write-port arbiter in front of the two-bank (two read, one shared write) pinwheel register file of 4 harts × 32 registers.
- Zero-clears the file after reset.
- Arbitrates the single write port between pipeline writeback and a debug/loader write port.
- Enforces x0 semantics.
- Provides a registered read-after-write bypass on both read ports.
- Sits between the pipeline/debug unit and the register-file instance.

---
 rtl/pinwheel_regfile_pkg.sv | 27 ++
 rtl/pinwheel_regfile_bypass.sv | 65 ++++++
 rtl/pinwheel_regfile_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pinwheel_regfile_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pinwheel_regfile_pkg.sv
// Purpose     : shared types and helpers for the pinwheel register-file controller.
// Latency     : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t       - controller sequencing state (CLEAR after reset, then RUN)
//   REG_IDX_BITS  - register index field width inside a file address
//   HART_BITS     - hart field width inside a file address
//   is_x0()       - true when a register index selects the hard-wired zero register
package pinwheel_regfile_pkg;

    // Address layout: addr[4:0] = register index, addr[6:5] = hart, addr[7] = 0.
    localparam int REG_IDX_BITS = 5;
    localparam int HART_BITS    = 2;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Takes only the register-index field so callers slice it explicitly and
    // the hart bits never leak into the x0 decision.
    function automatic logic is_x0(input logic [REG_IDX_BITS-1:0] addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/pinwheel_regfile_bypass.sv
// Purpose     : one read port's read-after-write bypass in front of a 1-cycle-latency RAM.
// Latency     : 1 cycle from i_raddr to o_rdata (matches the RAM read latency).
// Backpressure: none; captures every cycle, never stalls.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   i_raddr       - read address presented to the RAM this cycle
//   i_ram_wren    - RAM write enable this cycle (already x0/reset qualified)
//   i_ram_waddr   - RAM write address this cycle
//   i_ram_wdata   - RAM write data this cycle
//   i_ram_rdata   - RAM read data (for the address presented last cycle)
//   i_zero        - force the output to zero (clear sequence running)
//   o_rdata       - bypassed read data
module pinwheel_regfile_bypass
    import pinwheel_regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic                  i_ram_wren,
    input  logic [ADDR_WIDTH-1:0] i_ram_waddr,
    input  logic [DATA_WIDTH-1:0] i_ram_wdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,
    input  logic                  i_zero,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    // The RAM returns old data on a same-cycle read/write collision, so a
    // collision is remembered here and the new data substituted next cycle.
    logic                  w_hit;
    logic                  r_hit;
    logic                  r_x0;
    logic [DATA_WIDTH-1:0] r_wdata;

    assign w_hit = i_ram_wren && (i_ram_waddr == i_raddr);

    // Reset value of r_x0 is 1 so the port reads zero straight out of reset
    // (equivalent to a captured read address of 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit   <= 1'b0;
            r_x0    <= 1'b1;
            r_wdata <= '0;
        end else begin
            r_hit <= w_hit;
            r_x0  <= is_x0(i_raddr[REG_IDX_BITS-1:0]);
            if (w_hit) begin
                r_wdata <= i_ram_wdata;
            end
        end
    end

    always_comb begin
        o_rdata = i_ram_rdata;
        if (i_zero || r_x0) begin
            o_rdata = '0;
        end else if (r_hit) begin
            o_rdata = r_wdata;
        end
    end

endmodule

// File: rtl/pinwheel_regfile_ctrl.sv
// Purpose     : clear sequencer, write-port arbiter, x0 guard and read bypass for the pinwheel register file.
// Latency     : writes land at the next clock edge; reads return 1 cycle after the address.
// Backpressure: wb_stall holds writeback during clear/forced-debug cycles; dbg_ready handshakes debug writes.
//
// Configuration macro: PINWHEEL_REGFILE_CLEAR_EN
//   defined   - after reset the file is zero-cleared (DEPTH cycles, busy = 1)
//   undefined - reset lands directly in RUN, busy tied 0, no clear writes
//
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   rf_raddr0/1, rf_rdata0/1      - pipeline read ports (1-cycle latency, bypassed)
//   wb_wren/waddr/wdata, wb_stall - pipeline writeback and its hold request
//   dbg_valid/ready/waddr/wdata   - debug/loader write port (valid/ready)
//   busy                          - clear sequence in progress
//   ram_raddr0/1, ram_rdata0/1    - to/from register-file read ports
//   ram_waddr/wdata/wren          - to register-file shared write port
module pinwheel_regfile_ctrl
    import pinwheel_regfile_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 128,
    parameter int STALL_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rf_raddr0,
    input  logic [ADDR_WIDTH-1:0] rf_raddr1,
    output logic [DATA_WIDTH-1:0] rf_rdata0,
    output logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic                  wb_wren,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    output logic                  wb_stall,
    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic [ADDR_WIDTH-1:0] dbg_waddr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_raddr0,
    output logic [ADDR_WIDTH-1:0] ram_raddr1,
    input  logic [DATA_WIDTH-1:0] ram_rdata0,
    input  logic [DATA_WIDTH-1:0] ram_rdata1,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_wren
);

    localparam int                    CNT_W     = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0]      CNT_LIMIT = CNT_W'(STALL_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = ADDR_WIDTH'(DEPTH - 1);

`ifdef PINWHEEL_REGFILE_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = RUN;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      w_stall_cnt_nxt;

    logic                  w_in_clear;
    logic                  w_force;
    logic                  w_wb_grant;
    logic                  w_dbg_grant;
    logic                  w_wren;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_wb_stall;
    logic                  w_dbg_ready;
    logic                  w_ram_wren;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RESET_STATE;
            r_clr_addr  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_addr  <= w_clr_addr_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, clear sequencing and write-port arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_clr_addr_nxt  = r_clr_addr;
        w_stall_cnt_nxt = '0;
        w_in_clear      = 1'b0;
        w_force         = 1'b0;
        w_wb_grant      = 1'b0;
        w_dbg_grant     = 1'b0;
        w_waddr         = dbg_waddr;
        w_wdata         = dbg_wdata;
        w_wren          = 1'b0;
        w_wb_stall      = 1'b1;
        w_dbg_ready     = 1'b0;

        case (r_state)
            CLEAR: begin
                // One zero write per cycle; wb and dbg are ignored entirely.
                w_in_clear     = 1'b1;
                w_waddr        = r_clr_addr;
                w_wdata        = '0;
                w_wren         = 1'b1;
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (r_clr_addr == CLR_LAST) begin
                    w_state_nxt    = RUN;
                    w_clr_addr_nxt = '0;
                end
            end

            RUN: begin
                // Writeback wins unless debug has been refused STALL_LIMIT
                // cycles in a row; then debug is forced through and the
                // pipeline holds its write for this cycle.
                w_force     = (r_stall_cnt == CNT_LIMIT);
                w_wb_grant  = wb_wren && !w_force;
                w_dbg_grant = dbg_valid && !w_wb_grant;
                w_wb_stall  = w_force;
                w_dbg_ready = w_dbg_grant;

                if (w_wb_grant) begin
                    w_waddr = wb_waddr;
                    w_wdata = wb_wdata;
                end

                // x0 writes are dropped at the RAM but still handshake.
                w_wren = (w_wb_grant || w_dbg_grant) &&
                         !is_x0(w_waddr[REG_IDX_BITS-1:0]);

                if (dbg_valid && !w_dbg_grant) begin
                    w_stall_cnt_nxt = r_stall_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = RESET_STATE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The state registers are already held by the asynchronous reset; the
    // combinational handshake/write paths are also qualified with rst so
    // the outputs show reset values the moment rst rises.
    assign w_ram_wren = w_wren && !rst;
    assign ram_wren   = w_ram_wren;
    assign ram_waddr  = w_waddr;
    assign ram_wdata  = w_wdata;
    assign dbg_ready  = w_dbg_ready && !rst;
    assign wb_stall   = w_wb_stall || rst;

`ifdef PINWHEEL_REGFILE_CLEAR_EN
    assign busy = (r_state == CLEAR);
`else
    assign busy = 1'b0;
`endif

    assign ram_raddr0 = rf_raddr0;
    assign ram_raddr1 = rf_raddr1;

    pinwheel_regfile_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bypass0 (
        .clk         (clk),
        .rst         (rst),
        .i_raddr     (rf_raddr0),
        .i_ram_wren  (w_ram_wren),
        .i_ram_waddr (w_waddr),
        .i_ram_wdata (w_wdata),
        .i_ram_rdata (ram_rdata0),
        .i_zero      (w_in_clear),
        .o_rdata     (rf_rdata0)
    );

    pinwheel_regfile_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bypass1 (
        .clk         (clk),
        .rst         (rst),
        .i_raddr     (rf_raddr1),
        .i_ram_wren  (w_ram_wren),
        .i_ram_waddr (w_waddr),
        .i_ram_wdata (w_wdata),
        .i_ram_rdata (ram_rdata1),
        .i_zero      (w_in_clear),
        .o_rdata     (rf_rdata1)
    );

endmodule

// File: tb/tb_pinwheel_regfile_ctrl.sv
// Purpose     : directed self-checking bench for pinwheel_regfile_ctrl with a behavioural 1-cycle RAM.
// Latency     : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pinwheel_regfile_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;

`ifdef PINWHEEL_REGFILE_CLEAR_EN
    localparam logic RST_BUSY = 1'b1;
`else
    localparam logic RST_BUSY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rf_raddr0, rf_raddr1;
    logic [DW-1:0] rf_rdata0, rf_rdata1;
    logic          wb_wren;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          wb_stall;
    logic          dbg_valid, dbg_ready;
    logic [AW-1:0] dbg_waddr;
    logic [DW-1:0] dbg_wdata;
    logic          busy;
    logic [AW-1:0] ram_raddr0, ram_raddr1;
    logic [DW-1:0] ram_rdata0, ram_rdata1;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wren;

    // Behavioural register file: 1-cycle read, old data on collision.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] q0, q1;
    logic          ovr0;
    logic [DW-1:0] ovr_val;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        q0 <= mem[ram_raddr0];
        q1 <= mem[ram_raddr1];
        if (ram_wren) mem[ram_waddr] <= ram_wdata;
    end

    assign ram_rdata0 = ovr0 ? ovr_val : q0;
    assign ram_rdata1 = q1;

    pinwheel_regfile_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rf_raddr0  (rf_raddr0),
        .rf_raddr1  (rf_raddr1),
        .rf_rdata0  (rf_rdata0),
        .rf_rdata1  (rf_rdata1),
        .wb_wren    (wb_wren),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .wb_stall   (wb_stall),
        .dbg_valid  (dbg_valid),
        .dbg_ready  (dbg_ready),
        .dbg_waddr  (dbg_waddr),
        .dbg_wdata  (dbg_wdata),
        .busy       (busy),
        .ram_raddr0 (ram_raddr0),
        .ram_raddr1 (ram_raddr1),
        .ram_rdata0 (ram_rdata0),
        .ram_rdata1 (ram_rdata1),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .ram_wren   (ram_wren)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full clear: DEPTH cycles of zero writes at 0..127, with wb/dbg requests
    // held high to show they are ignored, then RUN with busy/wb_stall low.
    task automatic run_clear();
        wb_wren   = 1'b1;
        dbg_valid = 1'b1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            check_val("clear_cycle",
                      {busy, ram_wren, wb_stall, dbg_ready, ram_waddr, ram_wdata},
                      {4'b1110, 8'(i), 32'h0});
            cyc();
        end
        wb_wren   = 1'b0;
        dbg_valid = 1'b0;
        @(negedge clk);
        check_val("clear_done_busy", busy, 1'b0);
        check_val("clear_done_stall", wb_stall, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ovr0      = 1'b0;
        ovr_val   = '0;
        rst       = 1'b1;
        // Requests asserted during reset must have no effect.
        wb_wren   = 1'b1;
        wb_waddr  = 8'h25;
        wb_wdata  = 32'hFFFF_0000;
        dbg_valid = 1'b1;
        dbg_waddr = 8'h26;
        dbg_wdata = 32'h0BAD_0BAD;
        rf_raddr0 = 8'h25;
        rf_raddr1 = 8'h26;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", busy, RST_BUSY);
        check_val("rst_wb_stall", wb_stall, 1'b1);
        check_val("rst_dbg_ready", dbg_ready, 1'b0);
        check_val("rst_ram_wren", ram_wren, 1'b0);
        check_val("rst_rdata0", rf_rdata0, 32'h0);
        check_val("rst_rdata1", rf_rdata1, 32'h0);

        cyc();
        rst = 1'b0;
`ifdef PINWHEEL_REGFILE_CLEAR_EN
        run_clear();
`else
        wb_wren   = 1'b0;
        dbg_valid = 1'b0;
        @(negedge clk);
        check_val("run_busy", busy, 1'b0);
        check_val("run_wb_stall", wb_stall, 1'b0);
        check_val("run_idle_wren", ram_wren, 1'b0);
`endif

        // Writeback with same-cycle read: bypass, then RAM path.
        cyc();
        wb_wren   = 1'b1;
        wb_waddr  = 8'h25;
        wb_wdata  = 32'hDEAD_BEEF;
        rf_raddr0 = 8'h25;
        rf_raddr1 = 8'h25;
        @(negedge clk);
        check_val("wb_wren", ram_wren, 1'b1);
        check_val("wb_waddr", ram_waddr, 8'h25);
        check_val("wb_wdata", ram_wdata, 32'hDEAD_BEEF);
        check_val("raddr_pass", ram_raddr0, 8'h25);
        check_val("wb_no_stall", wb_stall, 1'b0);
        cyc();
        wb_wren = 1'b0;
        @(negedge clk);
        check_val("bypass0", rf_rdata0, 32'hDEAD_BEEF);
        check_val("bypass1", rf_rdata1, 32'hDEAD_BEEF);
        cyc();
        @(negedge clk);
        check_val("ram_path0", rf_rdata0, 32'hDEAD_BEEF);

        // Writeback to hart 2 x0 is dropped; x0 reads zero whatever the RAM says.
        cyc();
        wb_wren   = 1'b1;
        wb_waddr  = 8'h40;
        wb_wdata  = 32'h0000_0055;
        rf_raddr0 = 8'h40;
        @(negedge clk);
        check_val("x0_wb_wren", ram_wren, 1'b0);
        cyc();
        wb_wren = 1'b0;
        ovr0    = 1'b1;
        ovr_val = 32'h0000_1234;
        @(negedge clk);
        check_val("x0_read", rf_rdata0, 32'h0);
        cyc();
        rf_raddr0 = 8'h41;
        cyc();
        @(negedge clk);
        check_val("nonx0_ram_read", rf_rdata0, 32'h0000_1234);

        // wb beats dbg; dropping wb grants dbg in the same cycle.
        cyc();
        ovr0      = 1'b0;
        dbg_valid = 1'b1;
        dbg_waddr = 8'h33;
        dbg_wdata = 32'hCAFE_F00D;
        wb_wren   = 1'b1;
        wb_waddr  = 8'h21;
        wb_wdata  = 32'h1111_1111;
        @(negedge clk);
        check_val("arb_dbg_ready_lo", dbg_ready, 1'b0);
        check_val("arb_wb_waddr", ram_waddr, 8'h21);
        cyc();
        wb_wren = 1'b0;
        @(negedge clk);
        check_val("arb_dbg_ready_hi", dbg_ready, 1'b1);
        check_val("arb_dbg_waddr", ram_waddr, 8'h33);
        check_val("arb_dbg_wdata", ram_wdata, 32'hCAFE_F00D);
        check_val("arb_dbg_wren", ram_wren, 1'b1);
        cyc();
        dbg_valid = 1'b0;
        rf_raddr1 = 8'h33;
        cyc();
        @(negedge clk);
        check_val("dbg_readback", rf_rdata1, 32'hCAFE_F00D);

        // Debug write to x0 handshakes but does not write.
        cyc();
        dbg_valid = 1'b1;
        dbg_waddr = 8'h60;
        dbg_wdata = 32'h0000_0077;
        @(negedge clk);
        check_val("dbg_x0_ready", dbg_ready, 1'b1);
        check_val("dbg_x0_wren", ram_wren, 1'b0);

        // Starvation: 15 refusals, forced grant on cycle 16, counter back to 0.
        cyc();
        dbg_waddr = 8'h5A;
        dbg_wdata = 32'hA5A5_A5A5;
        wb_wren   = 1'b1;
        wb_waddr  = 8'h22;
        wb_wdata  = 32'h0000_2222;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 16)
                check_val("force_cycle", {wb_stall, dbg_ready, ram_waddr}, {2'b11, 8'h5A});
            else
                check_val("refuse_cycle", {wb_stall, dbg_ready, ram_waddr}, {2'b00, 8'h22});
            cyc();
        end
        dbg_valid = 1'b0;
        wb_waddr  = 8'h25;
        rf_raddr0 = 8'h5A;
        cyc();
        @(negedge clk);
        check_val("forced_readback", rf_rdata0, 32'hA5A5_A5A5);

        // Reset mid-RUN: outputs revert immediately.
        rst = 1'b1;
        #1;
        check_val("rst_run_wren", ram_wren, 1'b0);
        check_val("rst_run_stall", wb_stall, 1'b1);
        check_val("rst_run_rdata0", rf_rdata0, 32'h0);
        check_val("rst_run_busy", busy, RST_BUSY);
        wb_wren = 1'b0;
        cyc();
        rst = 1'b0;

`ifdef PINWHEEL_REGFILE_CLEAR_EN
        // Reset at clear address 60, then a complete restart from 0.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cyc();
        end
        @(negedge clk);
        check_val("clr_at_60", ram_waddr, 8'd60);
        rst = 1'b1;
        #1;
        check_val("rst_clr_wren", ram_wren, 1'b0);
        check_val("rst_clr_busy", busy, 1'b1);
        check_val("rst_clr_stall", wb_stall, 1'b1);
        cyc();
        rst = 1'b0;
        run_clear();
`else
        @(negedge clk);
        check_val("post_rst_busy", busy, 1'b0);
        check_val("post_rst_stall", wb_stall, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
